// File: rtl/pdp_preproc_mux_if.sv
// Beat handshake bundle around the PDP pre-processing mux: two selectable
// input streams (NaN stage, SDP) and one output stream to the calc core.
interface pdp_preproc_mux_if #(
  parameter int PW = 78
);
  logic [PW-1:0] nan_preproc_pd;
  logic          nan_preproc_pvld;
  logic          nan_preproc_prdy;
  logic [PW-1:0] sdp2pdp_pd;
  logic          sdp2pdp_valid;
  logic          sdp2pdp_ready;
  logic [PW-1:0] pre2cal_pd;
  logic          pre2cal_pvld;
  logic          pre2cal_prdy;

  modport slave (
    input  nan_preproc_pd, nan_preproc_pvld,
    output nan_preproc_prdy,
    input  sdp2pdp_pd, sdp2pdp_valid,
    output sdp2pdp_ready,
    output pre2cal_pd, pre2cal_pvld,
    input  pre2cal_prdy
  );

  modport master (
    output nan_preproc_pd, nan_preproc_pvld,
    input  nan_preproc_prdy,
    output sdp2pdp_pd, sdp2pdp_valid,
    input  sdp2pdp_ready,
    input  pre2cal_pd, pre2cal_pvld,
    output pre2cal_prdy
  );
endinterface

// File: rtl/pdp_preproc_mux.sv
// PDP input source select (off-fly NaN stage / on-fly SDP), 2-entry skid
// buffer toward the calc core, and per-layer beat counting and checking.
module pdp_preproc_mux #(
  parameter int DW = 64,
  parameter int IW = 14
) (
  input  logic        nvdla_core_clk,
  input  logic        nvdla_core_rstn,
  pdp_preproc_mux_if.slave io,
  input  logic        reg2dp_flying_mode,
  input  logic        reg2dp_op_en,
  input  logic [31:0] reg2dp_cube_beats,
  output logic        dp2reg_layer_done,
  output logic        dp2reg_beat_err,
  output logic [31:0] dp2reg_beat_num
);

  localparam int PW = DW + IW;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic          op_en_d1;
  logic          op_en_load;
  logic          idle_load;
  logic          mode_q;
  logic [31:0]   beat_cnt;
  logic          cnt_mismatch;

  logic [1:0]    buf_cnt;
  logic [1:0]    buf_cnt_nxt;
  logic          buf_not_full;
  logic [PW-1:0] buf_head;
  logic [PW-1:0] buf_tail;

  logic          in_pvld;
  logic [PW-1:0] in_pd;
  logic          accept;
  logic          pop;
  logic          layer_end;
  logic          drain_done;

  assign op_en_load = reg2dp_op_en & ~op_en_d1;
  assign idle_load  = (state == ST_IDLE) & op_en_load;

  assign io.nan_preproc_prdy = (state == ST_RUN) &  mode_q & buf_not_full;
  assign io.sdp2pdp_ready    = (state == ST_RUN) & ~mode_q & buf_not_full;

  assign in_pvld   = mode_q ? io.nan_preproc_pvld : io.sdp2pdp_valid;
  assign in_pd     = mode_q ? io.nan_preproc_pd   : io.sdp2pdp_pd;
  assign accept    = (state == ST_RUN) & buf_not_full & in_pvld;
  assign layer_end = in_pd[PW-1] & in_pd[DW+9];

  assign io.pre2cal_pvld = (buf_cnt != 2'd0);
  assign io.pre2cal_pd   = buf_head;
  assign pop             = io.pre2cal_pvld & io.pre2cal_prdy;

  // No pushes happen in DRAIN, so "empty next cycle" covers the final-pop cycle.
  assign drain_done   = (state == ST_DRAIN) & (buf_cnt_nxt == 2'd0);
  assign cnt_mismatch = ({1'b0, beat_cnt} != ({1'b0, reg2dp_cube_beats} + 33'd1));

  always_comb begin
    buf_cnt_nxt = buf_cnt;
    case ({accept, pop})
      2'b10:   buf_cnt_nxt = buf_cnt + 2'd1;
      2'b01:   buf_cnt_nxt = buf_cnt - 2'd1;
      default: buf_cnt_nxt = buf_cnt;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (op_en_load) state_nxt = ST_RUN;
      ST_RUN:   if (accept && layer_end) state_nxt = ST_DRAIN;
      ST_DRAIN: if (drain_done) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state    <= ST_IDLE;
      op_en_d1 <= 1'b0;
      mode_q   <= 1'b0;
      beat_cnt <= 32'd0;
    end else begin
      state    <= state_nxt;
      op_en_d1 <= reg2dp_op_en;
      if (idle_load) begin
        mode_q   <= reg2dp_flying_mode;
        beat_cnt <= 32'd0;
      end else if (accept && (beat_cnt != 32'hFFFF_FFFF)) begin
        beat_cnt <= beat_cnt + 32'd1;
      end
    end
  end

  // Head is always the oldest beat; the tail only holds a second beat when stalled.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      buf_cnt      <= 2'd0;
      buf_not_full <= 1'b1;
      buf_head     <= '0;
      buf_tail     <= '0;
    end else begin
      buf_cnt      <= buf_cnt_nxt;
      buf_not_full <= (buf_cnt_nxt != 2'd2);
      if (accept && ((buf_cnt == 2'd0) || ((buf_cnt == 2'd1) && pop))) begin
        buf_head <= in_pd;
      end else if (pop && (buf_cnt == 2'd2)) begin
        buf_head <= buf_tail;
      end
      if (accept && (((buf_cnt == 2'd1) && !pop) || (buf_cnt == 2'd2))) begin
        buf_tail <= in_pd;
      end
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      dp2reg_layer_done <= 1'b0;
      dp2reg_beat_err   <= 1'b0;
      dp2reg_beat_num   <= 32'd0;
    end else begin
      dp2reg_layer_done <= drain_done;
      if (drain_done) begin
        dp2reg_beat_num <= beat_cnt;
      end
      if (drain_done && cnt_mismatch) begin
        dp2reg_beat_err <= 1'b1;
      end else if (idle_load) begin
        dp2reg_beat_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pdp_preproc_mux.sv
// Directed bench for pdp_preproc_mux: layer bracketing, source selection,
// skid-buffer ordering/holding under backpressure, count checking, reset.
module tb_pdp_preproc_mux;

  localparam int PW = 78;

  logic        nvdla_core_clk = 1'b0;
  logic        nvdla_core_rstn;
  logic        reg2dp_flying_mode;
  logic        reg2dp_op_en;
  logic [31:0] reg2dp_cube_beats;
  logic        dp2reg_layer_done;
  logic        dp2reg_beat_err;
  logic [31:0] dp2reg_beat_num;

  pdp_preproc_mux_if #(.PW(PW)) bus ();

  pdp_preproc_mux #(.DW(64), .IW(14)) dut (
    .nvdla_core_clk     (nvdla_core_clk),
    .nvdla_core_rstn    (nvdla_core_rstn),
    .io                 (bus),
    .reg2dp_flying_mode (reg2dp_flying_mode),
    .reg2dp_op_en       (reg2dp_op_en),
    .reg2dp_cube_beats  (reg2dp_cube_beats),
    .dp2reg_layer_done  (dp2reg_layer_done),
    .dp2reg_beat_err    (dp2reg_beat_err),
    .dp2reg_beat_num    (dp2reg_beat_num)
  );

  always #5 nvdla_core_clk = ~nvdla_core_clk;

  int          nCompared = 0;
  int          nMismatched = 0;
  int          cyc = 0;
  int          firstAccCyc = 0;
  int          firstOutCyc = -1;
  logic        armFirst = 1'b0;
  logic        bpToggle = 1'b0;
  logic        prdyLevel = 1'b1;
  logic        prevStall = 1'b0;
  logic [PW-1:0] prevPd = '0;
  logic [PW-1:0] expQ[$];

  task automatic checkOutput(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] expv);
    nCompared++;
    if (obs !== expv) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  function automatic logic [PW-1:0] mkBeat(input bit last, input int idx);
    logic [8:0]  tag9;
    logic [63:0] data;
    tag9 = 9'(idx);
    data = 64'hA5A5_0000_0000_0000 | 64'(idx);
    return {last, 3'b000, last, tag9, data};
  endfunction

  always @(posedge nvdla_core_clk) cyc <= cyc + 1;

  // Output ready: fixed level or a 1/0 toggle for backpressure tests.
  always @(posedge nvdla_core_clk) begin
    #1;
    bus.pre2cal_prdy = bpToggle ? ~bus.pre2cal_prdy : prdyLevel;
  end

  // Output monitor: FIFO ordering against expQ and hold-while-stalled.
  always @(negedge nvdla_core_clk) begin
    if (nvdla_core_rstn === 1'b1) begin
      if (prevStall) begin
        checkOutput("hold_vld", PW'(bus.pre2cal_pvld), PW'(1));
        checkOutput("hold_pd", bus.pre2cal_pd, prevPd);
      end
      if (armFirst && bus.pre2cal_pvld) begin
        firstOutCyc = cyc;
        armFirst = 1'b0;
      end
      if (bus.pre2cal_pvld && bus.pre2cal_prdy) begin
        if (expQ.size() == 0) checkOutput("extra_beat", PW'(expQ.size()), PW'(1));
        else checkOutput("beat_order", bus.pre2cal_pd, expQ.pop_front());
      end
      prevStall = bus.pre2cal_pvld & ~bus.pre2cal_prdy;
      prevPd    = bus.pre2cal_pd;
    end else begin
      prevStall = 1'b0;
    end
  end

  task automatic applyStimulus(input bit mode, input logic [31:0] cube);
    reg2dp_flying_mode = mode;
    reg2dp_cube_beats  = cube;
    reg2dp_op_en       = 1'b1;
    @(posedge nvdla_core_clk); #2;
    reg2dp_op_en       = 1'b0;
  endtask

  task automatic sendBeats(input bit src, input int n, input int firstIdx, input bit endOnLast);
    logic [PW-1:0] beat;
    logic got;
    int tmo;
    for (int i = 0; i < n; i++) begin
      beat = mkBeat(endOnLast && (i == n - 1), firstIdx + i);
      if (src) begin bus.nan_preproc_pd = beat; bus.nan_preproc_pvld = 1'b1; end
      else     begin bus.sdp2pdp_pd     = beat; bus.sdp2pdp_valid    = 1'b1; end
      tmo = 0;
      forever begin
        @(negedge nvdla_core_clk);
        got = src ? bus.nan_preproc_prdy : bus.sdp2pdp_ready;
        checkOutput("other_rdy", PW'(src ? bus.sdp2pdp_ready : bus.nan_preproc_prdy), PW'(0));
        @(posedge nvdla_core_clk); #2;
        if (got) begin
          expQ.push_back(beat);
          if (i == 0) firstAccCyc = cyc;
          break;
        end
        tmo++;
        if (tmo > 200) begin
          checkOutput("accept_timeout", PW'(tmo), PW'(0));
          break;
        end
      end
    end
    if (src) bus.nan_preproc_pvld = 1'b0;
    else     bus.sdp2pdp_valid    = 1'b0;
  endtask

  task automatic waitDone(input logic [31:0] expNum, input bit expErr);
    int pulses = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge nvdla_core_clk);
      if (dp2reg_layer_done) pulses++;
    end
    checkOutput("done_pulses", PW'(pulses), PW'(1));
    checkOutput("beat_num", PW'(dp2reg_beat_num), PW'(expNum));
    checkOutput("beat_err", PW'(dp2reg_beat_err), PW'(expErr));
    checkOutput("drained", PW'(expQ.size()), PW'(0));
  endtask

  initial begin
    nvdla_core_rstn       = 1'b0;
    reg2dp_flying_mode    = 1'b0;
    reg2dp_op_en          = 1'b0;
    reg2dp_cube_beats     = 32'd0;
    bus.nan_preproc_pd    = '0;
    bus.nan_preproc_pvld  = 1'b0;
    bus.sdp2pdp_pd        = '0;
    bus.sdp2pdp_valid     = 1'b0;

    #12;
    $display("[TB] reset values");
    checkOutput("rst_pvld", PW'(bus.pre2cal_pvld), PW'(0));
    checkOutput("rst_pd", bus.pre2cal_pd, PW'(0));
    checkOutput("rst_nan_rdy", PW'(bus.nan_preproc_prdy), PW'(0));
    checkOutput("rst_sdp_rdy", PW'(bus.sdp2pdp_ready), PW'(0));
    checkOutput("rst_done", PW'(dp2reg_layer_done), PW'(0));
    checkOutput("rst_err", PW'(dp2reg_beat_err), PW'(0));
    checkOutput("rst_num", PW'(dp2reg_beat_num), PW'(0));
    @(posedge nvdla_core_clk); #2;
    nvdla_core_rstn = 1'b1;

    $display("[TB] idle gating");
    bus.nan_preproc_pd   = mkBeat(1'b1, 500);
    bus.nan_preproc_pvld = 1'b1;
    bus.sdp2pdp_pd       = mkBeat(1'b1, 501);
    bus.sdp2pdp_valid    = 1'b1;
    repeat (4) @(negedge nvdla_core_clk);
    checkOutput("idle_nan_rdy", PW'(bus.nan_preproc_prdy), PW'(0));
    checkOutput("idle_sdp_rdy", PW'(bus.sdp2pdp_ready), PW'(0));
    checkOutput("idle_pvld", PW'(bus.pre2cal_pvld), PW'(0));
    @(posedge nvdla_core_clk); #2;
    bus.nan_preproc_pvld = 1'b0;
    bus.sdp2pdp_valid    = 1'b0;

    $display("[TB] off-fly basic");
    prdyLevel = 1'b1;
    @(posedge nvdla_core_clk); #2;
    armFirst = 1'b1;
    applyStimulus(1'b1, 32'd3);
    sendBeats(1'b1, 4, 0, 1'b1);
    checkOutput("rdy_drop", PW'(bus.nan_preproc_prdy), PW'(0));
    waitDone(32'd4, 1'b0);
    checkOutput("latency", PW'(firstOutCyc), PW'(firstAccCyc));

    $display("[TB] on-fly backpressure");
    bpToggle = 1'b1;
    applyStimulus(1'b0, 32'd7);
    sendBeats(1'b0, 8, 10, 1'b1);
    checkOutput("rdy_drop_sdp", PW'(bus.sdp2pdp_ready), PW'(0));
    waitDone(32'd8, 1'b0);
    bpToggle  = 1'b0;
    prdyLevel = 1'b1;

    $display("[TB] count mismatch");
    applyStimulus(1'b1, 32'd9);
    sendBeats(1'b1, 6, 20, 1'b1);
    waitDone(32'd6, 1'b1);
    repeat (5) @(negedge nvdla_core_clk);
    checkOutput("err_sticky", PW'(dp2reg_beat_err), PW'(1));

    $display("[TB] mode switch and lost op_en edge");
    @(posedge nvdla_core_clk); #2;
    bus.nan_preproc_pd   = mkBeat(1'b1, 400);
    bus.nan_preproc_pvld = 1'b1;
    applyStimulus(1'b0, 32'd3);
    @(negedge nvdla_core_clk);
    checkOutput("err_cleared", PW'(dp2reg_beat_err), PW'(0));
    @(posedge nvdla_core_clk); #2;
    reg2dp_flying_mode = 1'b1;
    reg2dp_op_en       = 1'b1;
    @(posedge nvdla_core_clk); #2;
    reg2dp_op_en       = 1'b0;
    sendBeats(1'b0, 4, 30, 1'b1);
    waitDone(32'd4, 1'b0);
    checkOutput("post_nan_rdy", PW'(bus.nan_preproc_prdy), PW'(0));
    checkOutput("post_sdp_rdy", PW'(bus.sdp2pdp_ready), PW'(0));
    bus.nan_preproc_pvld = 1'b0;

    $display("[TB] async reset with buffered beats");
    prdyLevel = 1'b0;
    @(posedge nvdla_core_clk); #2;
    applyStimulus(1'b1, 32'd5);
    sendBeats(1'b1, 2, 40, 1'b0);
    @(negedge nvdla_core_clk);
    checkOutput("buf_pvld", PW'(bus.pre2cal_pvld), PW'(1));
    @(posedge nvdla_core_clk); #3;
    nvdla_core_rstn = 1'b0;
    #1;
    checkOutput("arst_pvld", PW'(bus.pre2cal_pvld), PW'(0));
    checkOutput("arst_pd", bus.pre2cal_pd, PW'(0));
    checkOutput("arst_nan_rdy", PW'(bus.nan_preproc_prdy), PW'(0));
    checkOutput("arst_num", PW'(dp2reg_beat_num), PW'(0));
    checkOutput("arst_done", PW'(dp2reg_layer_done), PW'(0));
    expQ.delete();
    prdyLevel = 1'b1;
    repeat (2) @(posedge nvdla_core_clk);
    #2;
    nvdla_core_rstn = 1'b1;
    bus.nan_preproc_pd   = mkBeat(1'b1, 600);
    bus.nan_preproc_pvld = 1'b1;
    repeat (2) @(negedge nvdla_core_clk);
    checkOutput("post_rst_idle", PW'(bus.nan_preproc_prdy), PW'(0));
    @(posedge nvdla_core_clk); #2;
    bus.nan_preproc_pvld = 1'b0;
    applyStimulus(1'b1, 32'd0);
    sendBeats(1'b1, 1, 50, 1'b1);
    waitDone(32'd1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
